// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: scans two operands MSB-first,
// DIGIT bits per clock, reporting eq/lt/gt with a start/done handshake.
module seq_mag_comparator #(
  parameter int WIDTH      = 8,
  parameter int DIGIT      = 2,
  parameter int EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             AeqB,
  output logic             AltB,
  output logic             AgtB
);

  localparam int D  = WIDTH / DIGIT;
  localparam int CW = (D > 1) ? $clog2(D) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPARE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] msbMask;
  logic [CW-1:0]    digitCnt;
  logic             ltHeld;
  logic             gtHeld;

  logic [DIGIT-1:0] digA;
  logic [DIGIT-1:0] digB;
  logic             undecided;
  logic             newLt;
  logic             newGt;
  logic             decided;
  logic             finish;

  // Flipping the MSB maps two's complement onto offset binary,
  // so the unsigned scan below orders signed values correctly.
  always_comb begin
    msbMask            = '0;
    msbMask[WIDTH-1]   = signed_mode;
  end

  assign digA      = opA[WIDTH-1 -: DIGIT];
  assign digB      = opB[WIDTH-1 -: DIGIT];
  assign undecided = !(ltHeld || gtHeld);
  assign newLt     = ltHeld || (undecided && (digA < digB));
  assign newGt     = gtHeld || (undecided && (digA > digB));
  assign decided   = newLt || newGt;
  assign finish    = ((EARLY_EXIT != 0) && decided)
                  || (digitCnt == '0);

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Control FSM, operand shifters and sticky first-difference decision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      opA      <= '0;
      opB      <= '0;
      digitCnt <= '0;
      ltHeld   <= 1'b0;
      gtHeld   <= 1'b0;
      AeqB     <= 1'b0;
      AltB     <= 1'b0;
      AgtB     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            opA      <= A ^ msbMask;
            opB      <= B ^ msbMask;
            digitCnt <= CW'(D - 1);
            ltHeld   <= 1'b0;
            gtHeld   <= 1'b0;
            AeqB     <= 1'b0;
            AltB     <= 1'b0;
            AgtB     <= 1'b0;
            state    <= COMPARE;
          end
        end
        COMPARE: begin
          opA      <= opA << DIGIT;
          opB      <= opB << DIGIT;
          digitCnt <= digitCnt - 1'b1;
          ltHeld   <= newLt;
          gtHeld   <= newGt;
          if (finish) begin
            AeqB  <= !decided;
            AltB  <= newLt;
            AgtB  <= newGt;
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Bench for seq_mag_comparator: four parameter variants driven by
// directed and random operations, checked against an arithmetic model.
module tb_seq_mag_comparator;

  localparam int PW[4] = '{8, 8, 16, 8};
  localparam int PD[4] = '{2, 2, 4, 8};
  localparam int PE[4] = '{1, 0, 1, 1};

  logic        clk;
  logic        rst_n;
  logic        startV [4];
  logic        smIn   [4];
  logic [15:0] aIn    [4];
  logic [15:0] bIn    [4];
  logic        busyO  [4];
  logic        doneO  [4];
  logic        eqO    [4];
  logic        ltO    [4];
  logic        gtO    [4];

  int compared;
  int mismatched;
  int cyc;
  int t0;
  int doneCnt [4];
  int doneAt  [4];
  int busyCnt [4];
  logic eqAt  [4];
  logic ltAt  [4];
  logic gtAt  [4];

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(startV[0]),
    .signed_mode(smIn[0]), .A(aIn[0][7:0]), .B(bIn[0][7:0]),
    .busy(busyO[0]), .done(doneO[0]),
    .AeqB(eqO[0]), .AltB(ltO[0]), .AgtB(gtO[0]));

  seq_mag_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(startV[1]),
    .signed_mode(smIn[1]), .A(aIn[1][7:0]), .B(bIn[1][7:0]),
    .busy(busyO[1]), .done(doneO[1]),
    .AeqB(eqO[1]), .AltB(ltO[1]), .AgtB(gtO[1]));

  seq_mag_comparator #(.WIDTH(16), .DIGIT(4), .EARLY_EXIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(startV[2]),
    .signed_mode(smIn[2]), .A(aIn[2]), .B(bIn[2]),
    .busy(busyO[2]), .done(doneO[2]),
    .AeqB(eqO[2]), .AltB(ltO[2]), .AgtB(gtO[2]));

  seq_mag_comparator #(.WIDTH(8), .DIGIT(8), .EARLY_EXIT(1)) u3 (
    .clk(clk), .rst_n(rst_n), .start(startV[3]),
    .signed_mode(smIn[3]), .A(aIn[3][7:0]), .B(bIn[3][7:0]),
    .busy(busyO[3]), .done(doneO[3]),
    .AeqB(eqO[3]), .AltB(ltO[3]), .AgtB(gtO[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record done pulses, their cycle and flags, and busy cycles.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (doneO[i]) begin
        doneCnt[i] = doneCnt[i] + 1;
        doneAt[i]  = cyc - t0 + 1;
        eqAt[i]    = eqO[i];
        ltAt[i]    = ltO[i];
        gtAt[i]    = gtO[i];
      end
      if (busyO[i]) busyCnt[i] = busyCnt[i] + 1;
    end
  end

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // First differing digit fixes latency; plain integer
  // comparison fixes the result.
  task automatic model(input int w, input int d, input int ee,
                       input logic [15:0] a, input logic [15:0] b,
                       input bit sm, output int lat,
                       output bit eq, output bit lt, output bit gt);
    longint m  = (longint'(1) << d) - 1;
    longint sa = longint'(a);
    longint sb = longint'(b);
    bit     found = 0;
    int     fk = 0;
    for (int j = 1; j <= w / d; j++) begin
      int sh = w - j * d;
      if (!found && (((sa >> sh) & m) != ((sb >> sh) & m))) begin
        found = 1;
        fk    = j;
      end
    end
    lat = (ee != 0 && found) ? fk + 1 : w / d + 1;
    if (sm && a[w-1]) sa = sa - (longint'(1) << w);
    if (sm && b[w-1]) sb = sb - (longint'(1) << w);
    eq = (sa == sb);
    lt = (sa < sb);
    gt = (sa > sb);
  endtask

  task automatic clearCounts();
    for (int i = 0; i < 4; i++) begin
      doneCnt[i] = 0;
      busyCnt[i] = 0;
      doneAt[i]  = -1;
    end
  endtask

  task automatic checkOp(input int i, input int lat, input bit eq,
                         input bit lt, input bit gt);
    chk($sformatf("u%0d doneCnt", i), doneCnt[i], 1);
    chk($sformatf("u%0d doneAt", i), doneAt[i], lat);
    chk($sformatf("u%0d busyCnt", i), busyCnt[i], lat);
    chk($sformatf("u%0d eqAtDone", i), eqAt[i], eq);
    chk($sformatf("u%0d ltAtDone", i), ltAt[i], lt);
    chk($sformatf("u%0d gtAtDone", i), gtAt[i], gt);
    chk($sformatf("u%0d eqHeld", i), eqO[i], eq);
    chk($sformatf("u%0d ltHeld", i), ltO[i], lt);
    chk($sformatf("u%0d gtHeld", i), gtO[i], gt);
    chk($sformatf("u%0d idle", i), busyO[i], 0);
  endtask

  task automatic op(input int i, input logic [15:0] a0,
                    input logic [15:0] b0, input bit sm);
    int          lat;
    bit          eq, lt, gt;
    logic [15:0] wm = 16'((32'd1 << PW[i]) - 1);
    logic [15:0] a  = a0 & wm;
    logic [15:0] b  = b0 & wm;
    model(PW[i], PD[i], PE[i], a, b, sm, lat, eq, lt, gt);
    @(negedge clk);
    clearCounts();
    aIn[i] = a; bIn[i] = b; smIn[i] = sm; startV[i] = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    startV[i] = 1'b0;
    aIn[i] = 16'($urandom);
    bIn[i] = 16'($urandom);
    smIn[i] = 1'($urandom);
    repeat (PW[i] / PD[i] + 3) @(negedge clk);
    #1;
    checkOp(i, lat, eq, lt, gt);
  endtask

  initial begin
    compared = 0; mismatched = 0; cyc = 0; t0 = 0;
    clearCounts();
    for (int i = 0; i < 4; i++) begin
      startV[i] = 0; smIn[i] = 0; aIn[i] = 0; bIn[i] = 0;
      eqAt[i] = 0; ltAt[i] = 0; gtAt[i] = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d rst busy", i), busyO[i], 0);
      chk($sformatf("u%0d rst done", i), doneO[i], 0);
      chk($sformatf("u%0d rst eq", i), eqO[i], 0);
      chk($sformatf("u%0d rst lt", i), ltO[i], 0);
      chk($sformatf("u%0d rst gt", i), gtO[i], 0);
    end
    rst_n = 1'b1;

    op(0, 16'h00, 16'h00, 0);
    op(0, 16'h80, 16'h7F, 0);
    op(0, 16'h80, 16'h7F, 1);
    op(0, 16'h13, 16'h12, 0);
    op(0, 16'hFE, 16'hFF, 1);

    // Start pulsed while busy must be ignored.
    @(negedge clk);
    clearCounts();
    aIn[0] = 16'h01; bIn[0] = 16'h02; smIn[0] = 0; startV[0] = 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    startV[0] = 0;
    @(negedge clk);
    @(negedge clk);
    aIn[0] = 16'hFF; bIn[0] = 16'h00; startV[0] = 1;
    @(posedge clk);
    #1;
    startV[0] = 0;
    repeat (5) @(negedge clk);
    #1;
    checkOp(0, 5, 0, 1, 0);

    // Asynchronous reset mid-operation aborts without a done.
    @(negedge clk);
    clearCounts();
    aIn[0] = 16'h33; bIn[0] = 16'h33; startV[0] = 1;
    @(posedge clk);
    #1;
    t0 = cyc;
    startV[0] = 0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort busy", busyO[0], 0);
    chk("abort done", doneO[0], 0);
    chk("abort eq", eqO[0], 0);
    chk("abort lt", ltO[0], 0);
    chk("abort gt", gtO[0], 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort noDone", doneCnt[0], 0);
    op(0, 16'h05, 16'h04, 0);

    op(1, 16'h80, 16'h7F, 0);
    op(2, 16'h1234, 16'h1234, 0);
    op(3, 16'h10, 16'h20, 0);

    for (int r = 0; r < 40; r++) begin
      int          i   = int'($urandom_range(0, 3));
      int          sel = int'($urandom_range(0, 2));
      logic [15:0] a   = 16'($urandom);
      logic [15:0] b   = 16'($urandom);
      if (sel == 1) b = a;
      if (sel == 2) b = a ^ (16'd1 << $urandom_range(0, PW[i] - 1));
      op(i, a, b, 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
